// File: rtl/pipe_trace_buffer_pkg.sv
// Shared types for the WB-stage trace buffer.
// TRACE_TIMESTAMP_EN adds a per-entry cycle timestamp field.
package pipe_trace_buffer_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_e;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [XLEN-1:0]   ts;
`endif
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic              rd_wren;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;
  } trace_entry_t;

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular WB-retire trace buffer with PC trigger, post-trigger window and pop readout.
// Optional feature: define TRACE_TIMESTAMP_EN to store a cycle timestamp per entry (o_rd_ts).
module pipe_trace_buffer
  import pipe_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_wb_vld,
  input  logic [XLEN-1:0]         i_wb_pc,
  input  logic [XLEN-1:0]         i_wb_inst,
  input  logic                    i_wb_rd_wren,
  input  logic [REG_AW-1:0]       i_wb_rd_addr,
  input  logic [XLEN-1:0]         i_wb_rd_data,
  input  logic                    i_arm,
  input  logic                    i_trig_en,
  input  logic [XLEN-1:0]         i_trig_pc,
  output logic                    o_rd_vld,
  input  logic                    i_rd_rdy,
  output logic [XLEN-1:0]         o_rd_pc,
  output logic [XLEN-1:0]         o_rd_inst,
  output logic                    o_rd_wren,
  output logic [REG_AW-1:0]       o_rd_addr,
  output logic [XLEN-1:0]         o_rd_data,
`ifdef TRACE_TIMESTAMP_EN
  output logic [XLEN-1:0]         o_rd_ts,
`endif
  output logic [1:0]              o_state,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = $bits(trace_entry_t);

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] post_q, post_d;
  logic          capture;
  logic          trig_hit;
  logic [AW-1:0] rd_ptr;
  trace_entry_t  wr_entry;
  trace_entry_t  rd_entry;

  // State and pointer registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      post_q   <= post_d;
    end
  end

  assign trig_hit = i_trig_en && i_wb_vld && (i_wb_pc == i_trig_pc);

  // Next-state: arm restarts from any state and outranks trigger and pop
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    post_d   = post_q;
    capture  = 1'b0;
    if (i_arm) begin
      state_d  = ST_ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
      post_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_ARMED: begin
          capture = i_wb_vld;
          if (trig_hit) begin
            if (POST_TRIG == 0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d = ST_POST;
              post_d  = AW'(POST_TRIG);
            end
          end
        end
        ST_POST: begin
          capture = i_wb_vld;
          if (i_wb_vld) begin
            post_d = post_q - AW'(1);
            if (post_q <= AW'(1)) begin
              state_d = ST_FROZEN;
            end
          end
        end
        ST_FROZEN: begin
          if (count_q == '0) begin
            state_d = ST_IDLE;
          end else if (i_rd_rdy) begin
            count_d = count_q - CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (capture) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (count_q != CW'(DEPTH)) begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [XLEN-1:0] ts_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + XLEN'(1);
    end
  end
`endif

  always_comb begin
    wr_entry         = '0;
    wr_entry.pc      = i_wb_pc;
    wr_entry.inst    = i_wb_inst;
    wr_entry.rd_wren = i_wb_rd_wren;
    wr_entry.rd_addr = i_wb_rd_addr;
    wr_entry.rd_data = i_wb_rd_data;
`ifdef TRACE_TIMESTAMP_EN
    wr_entry.ts      = ts_q;
`endif
  end

  // Oldest entry sits count entries behind the write pointer
  assign rd_ptr = wr_ptr_q - count_q[AW-1:0];

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_trace_ram (
    .i_clk (i_clk),
    .we    (capture),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Read fields are zeroed whenever nothing is offered, including in reset
  always_comb begin
    o_rd_vld  = (state_q == ST_FROZEN) && (count_q != '0);
    o_rd_pc   = o_rd_vld ? rd_entry.pc      : '0;
    o_rd_inst = o_rd_vld ? rd_entry.inst    : '0;
    o_rd_wren = o_rd_vld ? rd_entry.rd_wren : 1'b0;
    o_rd_addr = o_rd_vld ? rd_entry.rd_addr : '0;
    o_rd_data = o_rd_vld ? rd_entry.rd_data : '0;
`ifdef TRACE_TIMESTAMP_EN
    o_rd_ts   = o_rd_vld ? rd_entry.ts      : '0;
`endif
  end

  assign o_state = state_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: default instance plus a POST_TRIG=0 instance.
module tb_pipe_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_vld, wb_wren, arm, trig_en, rd_rdy;
  logic [31:0] wb_pc, wb_inst, wb_data, trig_pc;
  logic [4:0]  wb_addr;

  logic        rd_vld, rd_wren, rd_vld0, rd_wren0;
  logic [31:0] rd_pc, rd_inst, rd_data, rd_pc0, rd_inst0, rd_data0;
  logic [4:0]  rd_addr, rd_addr0, count, count0;
  logic [1:0]  state, state0;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] rd_ts, rd_ts0, ts_first;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_trace_buffer #(.DEPTH(16), .POST_TRIG(4)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_wb_vld(wb_vld), .i_wb_pc(wb_pc), .i_wb_inst(wb_inst),
    .i_wb_rd_wren(wb_wren), .i_wb_rd_addr(wb_addr), .i_wb_rd_data(wb_data),
    .i_arm(arm), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
    .o_rd_vld(rd_vld), .i_rd_rdy(rd_rdy), .o_rd_pc(rd_pc), .o_rd_inst(rd_inst),
    .o_rd_wren(rd_wren), .o_rd_addr(rd_addr), .o_rd_data(rd_data),
`ifdef TRACE_TIMESTAMP_EN
    .o_rd_ts(rd_ts),
`endif
    .o_state(state), .o_count(count)
  );

  pipe_trace_buffer #(.DEPTH(16), .POST_TRIG(0)) dut_pt0 (
    .i_clk(clk), .i_reset(rst_n), .i_wb_vld(wb_vld), .i_wb_pc(wb_pc), .i_wb_inst(wb_inst),
    .i_wb_rd_wren(wb_wren), .i_wb_rd_addr(wb_addr), .i_wb_rd_data(wb_data),
    .i_arm(arm), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
    .o_rd_vld(rd_vld0), .i_rd_rdy(rd_rdy), .o_rd_pc(rd_pc0), .o_rd_inst(rd_inst0),
    .o_rd_wren(rd_wren0), .o_rd_addr(rd_addr0), .o_rd_data(rd_data0),
`ifdef TRACE_TIMESTAMP_EN
    .o_rd_ts(rd_ts0),
`endif
    .o_state(state0), .o_count(count0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Retire one instruction; fields derived from the PC so readback is predictable
  task automatic retire(input logic [31:0] pc);
    wb_vld  = 1'b1;
    wb_pc   = pc;
    wb_inst = pc ^ 32'hA5A5_0000;
    wb_wren = pc[2];
    wb_addr = pc[6:2];
    wb_data = ~pc;
    step();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; wb_vld = 1'b0; wb_pc = '0; wb_inst = '0; wb_wren = 1'b0;
    wb_addr = '0; wb_data = '0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_vld", 32'(rd_vld), 32'd0);
    chk("rst_rd_pc", rd_pc, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Three retires without a trigger
    do_arm();
    chk("arm_state", 32'(state), 32'd1);
    chk("arm_count", 32'(count), 32'd0);
    retire(32'h0); retire(32'h4); retire(32'h8);
    wb_vld = 1'b0;
    chk("notrig_state", 32'(state), 32'd1);
    chk("notrig_count", 32'(count), 32'd3);
    chk("notrig_rd_vld", 32'(rd_vld), 32'd0);

    // Wrap-around capture with trigger at 0x40 and 4 post entries
    do_arm();
    trig_en = 1'b1; trig_pc = 32'h40;
    for (int k = 0; k < 30; k++) retire(32'(4 * k));
    wb_vld = 1'b0;
    chk("wrap_state", 32'(state), 32'd3);
    chk("wrap_count", 32'(count), 32'd16);
    chk("wrap0_state", 32'(state0), 32'd3);
    chk("wrap0_count", 32'(count0), 32'd16);
    chk("wrap0_oldest", rd_pc0, 32'h04);
    chk("wrap_inst", rd_inst, 32'h14 ^ 32'hA5A5_0000);
    chk("wrap_wren", 32'(rd_wren), 32'd1);
    chk("wrap_addr", 32'(rd_addr), 32'd5);
    chk("wrap_data", rd_data, ~32'h14);
    rd_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("wrap_vld", 32'(rd_vld), 32'd1);
      chk("wrap_pc", rd_pc, 32'(32'h14 + 4 * i));
      step();
    end
    rd_rdy = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_vld", 32'(rd_vld), 32'd0);
    chk("drain_state", 32'(state), 32'd3);
    step();
    chk("drain_idle", 32'(state), 32'd0);

    // Zero post window, trigger on first retire
    do_arm();
    trig_en = 1'b1; trig_pc = 32'h0;
    retire(32'h0);
    wb_vld = 1'b0;
    chk("pt0_state", 32'(state0), 32'd3);
    chk("pt0_count", 32'(count0), 32'd1);
    chk("pt0_vld", 32'(rd_vld0), 32'd1);
    chk("pt0_pc", rd_pc0, 32'h0);
    chk("pt0_data", rd_data0, 32'hFFFF_FFFF);
    chk("pt4_state", 32'(state), 32'd2);
    rd_rdy = 1'b1;
    step();
    rd_rdy = 1'b0;
    chk("pt0_popped", 32'(count0), 32'd0);
    chk("pt0_vld_after", 32'(rd_vld0), 32'd0);
    step();
    chk("pt0_idle", 32'(state0), 32'd0);

    // Back-pressure: rdy 1,0,1
    do_arm();
    trig_pc = 32'h40;
    for (int k = 0; k < 9; k++) retire(32'(32'h30 + 4 * k));
    wb_vld = 1'b0;
    chk("bp_state", 32'(state), 32'd3);
    chk("bp_count", 32'(count), 32'd9);
    chk("bp_pc0", rd_pc, 32'h30);
    rd_rdy = 1'b1; step();
    chk("bp_pc1", rd_pc, 32'h34);
    chk("bp_cnt1", 32'(count), 32'd8);
    rd_rdy = 1'b0; step();
    chk("bp_hold_pc", rd_pc, 32'h34);
    chk("bp_hold_data", rd_data, ~32'h34);
    chk("bp_hold_cnt", 32'(count), 32'd8);
    rd_rdy = 1'b1; step();
    rd_rdy = 1'b0;
    chk("bp_pc2", rd_pc, 32'h38);
    chk("bp_cnt2", 32'(count), 32'd7);

    // Re-arm during POST discards the old trace
    do_arm();
    retire(32'h38); retire(32'h3c); retire(32'h40); retire(32'h44);
    wb_vld = 1'b0;
    chk("post_state", 32'(state), 32'd2);
    chk("post_count", 32'(count), 32'd4);
    do_arm();
    chk("rearm_state", 32'(state), 32'd1);
    chk("rearm_count", 32'(count), 32'd0);
    chk("rearm_vld", 32'(rd_vld), 32'd0);
    for (int k = 0; k < 5; k++) retire(32'(32'h40 + 4 * k));
    wb_vld = 1'b0;
    chk("rearm_frozen", 32'(state), 32'd3);
    chk("rearm_cnt5", 32'(count), 32'd5);
    chk("rearm_oldest", rd_pc, 32'h40);

    // Asynchronous reset while frozen with 5 entries
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(rd_vld), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_pc", rd_pc, 32'h0);
    step();
    rst_n = 1'b1;
    step();

`ifdef TRACE_TIMESTAMP_EN
    // Consecutive-cycle retires carry timestamps one apart
    do_arm();
    trig_en = 1'b1; trig_pc = 32'h4;
    retire(32'h0); retire(32'h4);
    wb_vld = 1'b0;
    chk("ts_state", 32'(state0), 32'd3);
    chk("ts_pc0", rd_pc0, 32'h0);
    ts_first = rd_ts0;
    rd_rdy = 1'b1; step();
    rd_rdy = 1'b0;
    chk("ts_pc1", rd_pc0, 32'h4);
    chk("ts_delta", rd_ts0 - ts_first, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
